tetromino_board_writer: RTL and testbench
=========================================

Name: tetromino_board_writer

Overview:
- Sequenced engine that stamps a tetromino's four cells into the 10x20 playfield board RAM, or reads them back. The pixel renderers only map geometry to screen pixels; this block maps the same geometry onto board storage.
- Sits between the game-logic controller (MIPS MMIO side) and the board RAM port.
- Supports three operations:
  - CHECK: collision test.
  - LOCK: write the piece colour.
  - ERASE: write zero.

Parameters:
- COLS, 10, board width in cells.
- ROWS, 20, board height in cells.
- CW, 3, cell colour width; 0 = empty.
- AW, 8, board RAM address width.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled in IDLE only.
- op  in  2  0=CHECK, 1=LOCK, 2=ERASE, 3=reserved (treated as CHECK).
- piece_type  in  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L, 7=invalid.
- rotation  in  2  quarter turns clockwise.
- org_col  in  4  column of the 4x4 bounding box origin.
- org_row  in  5  row of the 4x4 bounding box origin.
- color  in  CW  colour written by LOCK.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- collision  out  1  result: any cell occupied or out of bounds.
- oob  out  1  result: any cell out of bounds.
- rd_en  out  1  board read strobe.
- rd_addr  out  AW  board read address.
- rd_data  in  CW  board read data, valid the cycle after rd_en.
- wr_en  out  1  board write strobe.
- wr_addr  out  AW  board write address.
- wr_data  out  CW  board write data.

Behaviour:
- Clocking and reset:
  - One clock domain: clock, posedge.
  - resetn is asynchronous and active-low.
  - While resetn=0: state=IDLE; busy, done, collision, oob, rd_en, wr_en = 0; addresses and wr_data = 0.
  - Reset mid-operation aborts immediately. wr_en drops asynchronously and no further board accesses occur.
- Cell geometry:
  - Offsets (dx,dy), each 0..3, come from a package ROM indexed by {piece_type, rotation, idx}, idx 0..3.
  - Cell coordinate: c = org_col+dx and r = org_row+dy, computed 6 bits wide with no wrap.
  - A cell is out of bounds when c>=COLS or r>=ROWS.
  - Address = r*COLS + c, truncated to AW bits; only used when the cell is in bounds.
- Start acceptance:
  - In IDLE, start=1 latches op, piece_type, rotation, org_col, org_row and color.
  - It also clears collision and oob, sets idx=0 and busy=1, and moves to CELL.
  - start while busy is ignored; the inputs are not re-sampled.
- State CELL (evaluates cell idx):
  - Out of bounds: set oob=1 and collision=1, perform no access, advance.
  - CHECK, in bounds: rd_en=1 and rd_addr=address for one cycle, then go to READ.
  - LOCK or ERASE, in bounds: wr_en=1, wr_addr=address and wr_data=(LOCK ? color : 0) for exactly one cycle, then advance.
  - LOCK writes in-bounds cells even when other cells are out of bounds. Callers must CHECK first.
- State READ: if rd_data != 0, set collision=1; then advance.
- Advance: if idx==3, go to DONE; otherwise idx++ and return to CELL.
- State DONE:
  - done=1 for one cycle, busy=0, return to IDLE.
  - collision and oob hold until the next accepted start.
- Latency, with start accepted at edge T:
  - CHECK, all in bounds: done at T+9.
  - LOCK or ERASE: done at T+5.
  - Each out-of-bounds cell costs 1 cycle.
- Invalid piece_type 7: go CELL -> DONE without accesses; collision=1, oob=1, done at T+2.
- Cell order is always idx 0..3.
- rd_en and wr_en are never asserted in the same cycle.

Decomposition:
- Shared package tetris_pkg holds:
  - piece and op encodings;
  - COLS and ROWS;
  - the offset ROM, e.g. T rot0 = (1,0),(0,1),(1,1),(2,1); I rot0 = (0,1),(1,1),(2,1),(3,1); O = (1,0),(2,0),(1,1),(2,1) for all rotations.
- Sub-module tetromino_cells: combinational lookup of {type, rot, idx} -> (dx, dy, valid). It is shared later with the renderers.

Test Plan:
- LOCK T rot0 at org (3,5) with color=5 -> writes to addrs 54, 63, 64, 65 with data 5, one per cycle; done at T+5; collision=0.
- CHECK the same piece with addr 64 holding 2 -> reads 54, 63, 64, 65; collision=1, oob=0; done at T+9.
- CHECK I rot0 at org (8,0) -> cells c=8,9,10,11 at r=1. Expected: oob=1 and collision=1; 2 reads (addrs 18, 19); done at T+7.
- ERASE O at org (0,18) -> writes 0 to 181, 182, 191, 192.
- start pulsed while busy, then resetn low during LOCK after 2 writes -> the second start is ignored; after reset, no further wr_en and all outputs are 0.
- piece_type=7 -> no rd_en or wr_en; done at T+2 with collision=1, oob=1.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared tetromino encodings, playfield size and the 4x4 cell-offset ROM.
// Each ROM word holds four cells, idx 0 in the top nibble, each nibble {dx[1:0], dy[1:0]}.
package tetris_pkg;

   localparam int unsigned COLS = 10;
   localparam int unsigned ROWS = 20;

   typedef enum logic [1:0] {
      OpCheck = 2'd0,
      OpLock  = 2'd1,
      OpErase = 2'd2,
      OpRsvd  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      PcI       = 3'd0,
      PcO       = 3'd1,
      PcT       = 3'd2,
      PcS       = 3'd3,
      PcZ       = 3'd4,
      PcJ       = 3'd5,
      PcL       = 3'd6,
      PcInvalid = 3'd7
   } piece_e;

   // Indexed by {piece_type, rotation}; cells listed in raster order of the 4x4 box.
   localparam logic [0:31][15:0] SHAPE_ROM = '{
      16'h159D, 16'h89AB, 16'h26AE, 16'h4567,
      16'h4859, 16'h4859, 16'h4859, 16'h4859,
      16'h4159, 16'h4596, 16'h1596, 16'h4156,
      16'h4815, 16'h459A, 16'h5926, 16'h0156,
      16'h0459, 16'h8596, 16'h156A, 16'h4152,
      16'h0159, 16'h4856, 16'h159A, 16'h4526,
      16'h8159, 16'h456A, 16'h1592, 16'h0456,
      16'h0000, 16'h0000, 16'h0000, 16'h0000
   };

endpackage

// File: rtl/tetromino_board_writer_if.sv
// Request/result handshake plus board RAM port of the tetromino board writer.
interface tetromino_board_writer_if #(
   parameter int unsigned CW = 3,
   parameter int unsigned AW = 8
);
   logic          start;
   logic [1:0]    op;
   logic [2:0]    piece_type;
   logic [1:0]    rotation;
   logic [3:0]    org_col;
   logic [4:0]    org_row;
   logic [CW-1:0] color;
   logic          busy;
   logic          done;
   logic          collision;
   logic          oob;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [CW-1:0] wr_data;

   modport master (
      output start, op, piece_type, rotation, org_col, org_row, color, rd_data,
      input  busy, done, collision, oob, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  start, op, piece_type, rotation, org_col, org_row, color, rd_data,
      output busy, done, collision, oob, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/tetromino_cells.sv
// Combinational lookup of one tetromino cell offset: {type, rot, idx} -> (dx, dy, valid).
module tetromino_cells
   import tetris_pkg::*;
(
   input  logic [2:0] i_piece_type,
   input  logic [1:0] i_rotation,
   input  logic [1:0] i_idx,
   output logic [1:0] o_dx,
   output logic [1:0] o_dy,
   output logic       o_valid
);

   logic [15:0] w_shape;
   logic [1:0]  w_sel;
   logic [3:0]  w_cell;

   assign w_shape = SHAPE_ROM[{i_piece_type, i_rotation}];
   assign w_sel   = 2'd3 - i_idx;
   assign w_cell  = w_shape[{w_sel, 2'b00} +: 4];
   assign o_dx    = w_cell[3:2];
   assign o_dy    = w_cell[1:0];
   assign o_valid = (i_piece_type != PcInvalid);

endmodule

// File: rtl/tetromino_board_writer.sv
// Sequenced engine that checks, locks or erases a tetromino's four cells in board RAM,
// one cell per step in idx order 0..3.
module tetromino_board_writer
   import tetris_pkg::*;
#(
   parameter int unsigned CW = 3,
   parameter int unsigned AW = 8
) (
   input logic                   clock,
   input logic                   resetn,
   tetromino_board_writer_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CELL = 2'd1;
   localparam logic [1:0] ST_READ = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [1:0]    r_op;
   logic [2:0]    r_ptype;
   logic [1:0]    r_rot;
   logic [3:0]    r_col;
   logic [4:0]    r_row;
   logic [CW-1:0] r_color;
   logic [1:0]    r_idx;
   logic          r_collision;
   logic          r_oob;

   logic [1:0]    w_dx;
   logic [1:0]    w_dy;
   logic          w_valid;
   logic [5:0]    w_c;
   logic [5:0]    w_r;
   logic          w_oob;
   logic [9:0]    w_addr_full;
   logic [AW-1:0] w_addr;
   logic          w_is_check;
   logic          w_cell_ok;
   logic          w_rd_en;
   logic          w_wr_en;
   logic          w_accept;
   logic          w_advance;

   tetromino_cells u_cells (
      .i_piece_type (r_ptype),
      .i_rotation   (r_rot),
      .i_idx        (r_idx),
      .o_dx         (w_dx),
      .o_dy         (w_dy),
      .o_valid      (w_valid)
   );

   // Coordinates are 6 bits so an origin near the edge never wraps back in bounds.
   assign w_c         = {2'b00, r_col} + {4'b0000, w_dx};
   assign w_r         = {1'b0, r_row} + {4'b0000, w_dy};
   assign w_oob       = (w_c >= 6'(COLS)) || (w_r >= 6'(ROWS));
   assign w_addr_full = ({4'b0000, w_r} * 10'(COLS)) + {4'b0000, w_c};
   assign w_addr      = AW'(w_addr_full);

   // Reserved op code behaves as CHECK.
   assign w_is_check  = (r_op != OpLock) && (r_op != OpErase);
   assign w_cell_ok   = (r_state == ST_CELL) && w_valid && !w_oob;
   assign w_rd_en     = w_cell_ok && w_is_check;
   assign w_wr_en     = w_cell_ok && !w_is_check;
   assign w_accept    = (r_state == ST_IDLE) && bus.start;
   assign w_advance   = ((r_state == ST_CELL) && w_valid && !w_rd_en) || (r_state == ST_READ);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_state_next = ST_CELL;
         ST_CELL: begin
            if (!w_valid)          w_state_next = ST_DONE;
            else if (w_rd_en)      w_state_next = ST_READ;
            else if (r_idx == 2'd3) w_state_next = ST_DONE;
            else                   w_state_next = ST_CELL;
         end
         ST_READ: w_state_next = (r_idx == 2'd3) ? ST_DONE : ST_CELL;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_ptype     <= '0;
         r_rot       <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_color     <= '0;
         r_idx       <= '0;
         r_collision <= 1'b0;
         r_oob       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op        <= bus.op;
            r_ptype     <= bus.piece_type;
            r_rot       <= bus.rotation;
            r_col       <= bus.org_col;
            r_row       <= bus.org_row;
            r_color     <= bus.color;
            r_idx       <= '0;
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
         end
         if ((r_state == ST_CELL) && (!w_valid || w_oob)) begin
            r_collision <= 1'b1;
            r_oob       <= 1'b1;
         end
         if ((r_state == ST_READ) && (bus.rd_data != '0)) r_collision <= 1'b1;
         if (w_advance) r_idx <= r_idx + 2'd1;
      end
   end

   // Strobes and addresses decode straight from state, so reset clears them at once.
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = w_rd_en ? w_addr : '0;
   assign bus.wr_en     = w_wr_en;
   assign bus.wr_addr   = w_wr_en ? w_addr : '0;
   assign bus.wr_data   = (w_wr_en && (r_op == OpLock)) ? r_color : '0;
   assign bus.busy      = (r_state == ST_CELL) || (r_state == ST_READ);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.collision = r_collision;
   assign bus.oob       = r_oob;

endmodule

// File: tb/tb_tetromino_board_writer.sv
// Randomized bench for tetromino_board_writer: shapes are rebuilt by rotating the spawn
// bitmap, and accesses, flags, latency and board contents are compared against that model.
module tb_tetromino_board_writer;

   localparam int unsigned CW = 3;
   localparam int unsigned AW = 8;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   tetromino_board_writer_if #(.CW(CW), .AW(AW)) bus_if ();

   tetromino_board_writer #(.CW(CW), .AW(AW)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus_if)
   );

   always #5 clock = ~clock;

   logic [CW-1:0] ram      [256];
   logic [CW-1:0] init_mem [256];
   logic [CW-1:0] ref_mem  [256];
   logic          bd_load = 1'b0;
   int            edge_cnt = 0;

   // Board RAM with one-cycle read latency and a single-cycle backdoor bulk load.
   always @(posedge clock) begin
      edge_cnt <= edge_cnt + 1;
      if (bd_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_mem[i];
      end else begin
         if (bus_if.rd_en) bus_if.rd_data <= ram[bus_if.rd_addr];
         if (bus_if.wr_en) ram[bus_if.wr_addr] <= bus_if.wr_data;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Spawn-orientation bitmaps, bit y*4+x.
   function automatic logic [15:0] base_grid(input int p);
      case (p)
         0:       return 16'h00F0;
         1:       return 16'h0066;
         2:       return 16'h0072;
         3:       return 16'h0036;
         4:       return 16'h0063;
         5:       return 16'h0071;
         default: return 16'h0074;
      endcase
   endfunction

   // Quarter turn clockwise inside an n x n box: (x,y) -> (n-1-y, x).
   function automatic logic [15:0] rotate_cw(input logic [15:0] g, input int n);
      logic [15:0] r;
      r = '0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            if (g[y*4+x]) r[x*4 + (n-1-y)] = 1'b1;
      return r;
   endfunction

   function automatic int enc(input int kind, input int addr, input int data);
      return kind*4096 + addr*8 + data;
   endfunction

   int exp_q[$];
   int got_q[$];
   int exp_col, exp_oob, exp_lat;
   int last_lat;

   task automatic model(input int op, input int p, input int rot, input int col, input int row,
                        input int color);
      logic [15:0] g;
      int c, r, a, d;
      exp_q.delete();
      exp_col = 0;
      exp_oob = 0;
      exp_lat = 1;
      if (p == 7) begin
         exp_col = 1;
         exp_oob = 1;
         exp_lat = 2;
         return;
      end
      g = base_grid(p);
      if (p != 1) repeat (rot) g = rotate_cw(g, (p == 0) ? 4 : 3);
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            if (g[y*4+x]) begin
               c = col + x;
               r = row + y;
               if (c >= 10 || r >= 20) begin
                  exp_oob = 1;
                  exp_col = 1;
                  exp_lat += 1;
               end else begin
                  a = r*10 + c;
                  if (op == 1 || op == 2) begin
                     d = (op == 1) ? color : 0;
                     exp_q.push_back(enc(2, a, d));
                     ref_mem[a] = CW'(d);
                     exp_lat += 1;
                  end else begin
                     exp_q.push_back(enc(1, a, 0));
                     if (ref_mem[a] != '0) exp_col = 1;
                     exp_lat += 2;
                  end
               end
            end
         end
      end
   endtask

   task automatic push_board();
      @(negedge clock);
      bd_load = 1'b1;
      @(negedge clock);
      bd_load = 1'b0;
   endtask

   task automatic fill_board(input int density);
      for (int i = 0; i < 256; i++) begin
         init_mem[i] = ($urandom_range(0, 99) < density) ? CW'($urandom_range(1, 7)) : '0;
         ref_mem[i]  = init_mem[i];
      end
   endtask

   task automatic run_op(input int op, input int p, input int rot, input int col, input int row,
                         input int color);
      int e_start, overlap, nmis;
      bit done_seen;
      @(negedge clock);
      bus_if.start      = 1'b1;
      bus_if.op         = 2'(op);
      bus_if.piece_type = 3'(p);
      bus_if.rotation   = 2'(rot);
      bus_if.org_col    = 4'(col);
      bus_if.org_row    = 5'(row);
      bus_if.color      = CW'(color);
      e_start           = edge_cnt;
      model(op, p, rot, col, row, color);
      got_q.delete();
      overlap   = 0;
      done_seen = 1'b0;
      last_lat  = -1;
      for (int k = 0; k < 40 && !done_seen; k++) begin
         @(negedge clock);
         if (k == 0) begin
            bus_if.start = 1'b0;
            check_eq("busy_run", 32'(bus_if.busy), 1);
         end
         if (bus_if.rd_en && bus_if.wr_en) overlap++;
         if (bus_if.rd_en) got_q.push_back(enc(1, int'(bus_if.rd_addr), 0));
         if (bus_if.wr_en) got_q.push_back(enc(2, int'(bus_if.wr_addr), int'(bus_if.wr_data)));
         if (bus_if.done) begin
            done_seen = 1'b1;
            last_lat  = edge_cnt - e_start;
            check_eq("busy_at_done", 32'(bus_if.busy), 0);
         end
      end
      check_eq("done_seen", 32'(done_seen), 1);
      check_eq("latency", last_lat, exp_lat);
      check_eq("n_access", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check_eq("access", got_q[i], exp_q[i]);
      check_eq("rd_wr_overlap", overlap, 0);
      @(negedge clock);
      check_eq("collision", 32'(bus_if.collision), exp_col);
      check_eq("oob", 32'(bus_if.oob), exp_oob);
      nmis = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) nmis++;
      check_eq("board", nmis, 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(bus_if.busy), 0);
      check_eq({tag, "_done"}, 32'(bus_if.done), 0);
      check_eq({tag, "_col"}, 32'(bus_if.collision), 0);
      check_eq({tag, "_oob"}, 32'(bus_if.oob), 0);
      check_eq({tag, "_rd_en"}, 32'(bus_if.rd_en), 0);
      check_eq({tag, "_wr_en"}, 32'(bus_if.wr_en), 0);
      check_eq({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 0);
      check_eq({tag, "_wr_addr"}, 32'(bus_if.wr_addr), 0);
      check_eq({tag, "_wr_data"}, 32'(bus_if.wr_data), 0);
   endtask

   initial begin
      int strobes;
      bus_if.start      = 1'b0;
      bus_if.op         = '0;
      bus_if.piece_type = '0;
      bus_if.rotation   = '0;
      bus_if.org_col    = '0;
      bus_if.org_row    = '0;
      bus_if.color      = '0;
      fill_board(0);
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      push_board();
      resetn = 1'b1;

      // LOCK T rot0 at (3,5), colour 5.
      run_op(1, 2, 0, 3, 5, 5);
      check_eq("lock_t_lat", last_lat, 5);
      check_eq("lock_t_first", got_q.size() > 0 ? got_q[0] : -1, enc(2, 54, 5));
      check_eq("lock_t_last", got_q.size() > 3 ? got_q[3] : -1, enc(2, 65, 5));

      // CHECK the same piece with only cell 64 occupied.
      fill_board(0);
      init_mem[64] = 3'd2;
      ref_mem[64]  = 3'd2;
      push_board();
      run_op(0, 2, 0, 3, 5, 0);
      check_eq("check_t_lat", last_lat, 9);
      check_eq("check_t_col", 32'(bus_if.collision), 1);
      check_eq("check_t_oob", 32'(bus_if.oob), 0);

      // CHECK I rot0 hanging off the right edge.
      run_op(0, 0, 0, 8, 0, 0);
      check_eq("check_i_lat", last_lat, 7);
      check_eq("check_i_reads", got_q.size(), 2);
      check_eq("check_i_oob", 32'(bus_if.oob), 1);

      // ERASE O at the bottom rows over a busy board.
      fill_board(70);
      push_board();
      run_op(2, 1, 0, 0, 18, 0);
      check_eq("erase_o_181", 32'(ram[181]), 0);
      check_eq("erase_o_192", 32'(ram[192]), 0);

      // Invalid piece type.
      run_op(1, 7, 1, 2, 2, 4);
      check_eq("invalid_lat", last_lat, 2);
      check_eq("invalid_acc", got_q.size(), 0);

      // Randomized operations.
      for (int n = 0; n < 80; n++) begin
         if (n % 8 == 0) begin
            fill_board($urandom_range(0, 60));
            push_board();
         end
         if ($urandom_range(0, 3) == 0)
            run_op($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 7));
         else
            run_op($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 8), $urandom_range(0, 18), $urandom_range(0, 7));
      end

      // LOCK interrupted by reset after two writes; a start while busy must be ignored.
      fill_board(0);
      push_board();
      @(negedge clock);
      bus_if.start      = 1'b1;
      bus_if.op         = 2'd1;
      bus_if.piece_type = 3'd2;
      bus_if.rotation   = 2'd0;
      bus_if.org_col    = 4'd3;
      bus_if.org_row    = 5'd5;
      bus_if.color      = 3'd5;
      @(negedge clock);
      bus_if.start = 1'b0;
      check_eq("rst_w1_addr", 32'(bus_if.wr_addr), 54);
      bus_if.start      = 1'b1;
      bus_if.op         = 2'd2;
      bus_if.piece_type = 3'd0;
      bus_if.org_col    = 4'd0;
      bus_if.org_row    = 5'd0;
      @(negedge clock);
      bus_if.start = 1'b0;
      check_eq("rst_w2_addr", 32'(bus_if.wr_addr), 63);
      check_eq("rst_w2_data", 32'(bus_if.wr_data), 5);
      @(posedge clock);
      #1;
      check_eq("rst_w3_pending", 32'(bus_if.wr_en), 1);
      resetn = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      strobes = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus_if.wr_en || bus_if.rd_en) strobes++;
      end
      resetn = 1'b1;
      repeat (8) begin
         @(negedge clock);
         if (bus_if.wr_en || bus_if.rd_en || bus_if.done) strobes++;
      end
      check_eq("post_rst_strobes", strobes, 0);
      check_outputs_zero("post_rst");
      check_eq("rst_ram54", 32'(ram[54]), 5);
      check_eq("rst_ram63", 32'(ram[63]), 5);
      check_eq("rst_ram64", 32'(ram[64]), 0);
      check_eq("rst_ram65", 32'(ram[65]), 0);
      check_eq("rst_ram0", 32'(ram[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
